// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_frame serial front end.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Data is zero-extended to 9 bits; padding zeros do not change the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input parity_t mode);
    case (mode)
      PAR_EVEN: return ^data;
      PAR_ODD:  return ~^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes (used with UART_RX_FIFO_EN).
module uart_rx_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_rd;
  logic         do_wr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign do_rd   = rd_en && !empty;
  // A read in the same cycle frees the slot, so a write while full still lands.
  assign do_wr   = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame.sv
// Full-duplex UART with configurable data/parity/stop framing and error reporting.
// Define UART_RX_FIFO_EN to replace the RX holding register with a FIFO_DEPTH-entry FIFO.
module uart_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK      = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA       = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP       = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DATA-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic            tx,
  input  logic            rx,
  output logic [DATA-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun
);

  localparam int unsigned DIV = CLOCK / BAUD;
  localparam int unsigned CW  = $clog2(DIV);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP - 1);
  localparam parity_t       PMODE     = parity_t'(2'(PARITY));

  if (DIV < 4 || DATA < 5 || DATA > 9 || PARITY > 2 || STOP < 1 || STOP > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_frame: unsupported parameter set");
  end

  // ---------------- transmitter ----------------
  tx_state_t       tx_state;
  logic [CW-1:0]   tx_cnt;
  logic [3:0]      tx_bit;
  logic [DATA-1:0] tx_shreg;
  logic            tx_par;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
    end else if (tx_state == TX_IDLE) begin
      tx_cnt <= '0;
      if (tx_valid) begin
        tx_shreg <= tx_data;
        tx_par   <= parity_bit(9'(tx_data), PMODE);
        tx       <= 1'b0;
        tx_ready <= 1'b0;
        tx_state <= TX_START;
      end
    end else if (tx_cnt != CNT_LAST) begin
      tx_cnt <= tx_cnt + 1'b1;
    end else begin
      tx_cnt <= '0;
      case (tx_state)
        TX_START: begin
          tx       <= tx_shreg[0];
          tx_shreg <= tx_shreg >> 1;
          tx_bit   <= '0;
          tx_state <= TX_DATA;
        end
        TX_DATA: begin
          if (tx_bit == DATA_LAST) begin
            tx_bit <= '0;
            if (PARITY != 0) begin
              tx       <= tx_par;
              tx_state <= TX_PARITY;
            end else begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end
          end else begin
            tx       <= tx_shreg[0];
            tx_shreg <= tx_shreg >> 1;
            tx_bit   <= tx_bit + 1'b1;
          end
        end
        TX_PARITY: begin
          tx       <= 1'b1;
          tx_bit   <= '0;
          tx_state <= TX_STOP;
        end
        TX_STOP: begin
          if (tx_bit == STOP_LAST) begin
            tx_ready <= 1'b1;
            tx_state <= TX_IDLE;
          end else begin
            tx_bit <= tx_bit + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  rx_state_t       rx_state;
  logic            rx_s1;
  logic            rx_s2;
  logic [CW-1:0]   rx_cnt;
  logic [3:0]      rx_bit;
  logic [DATA-1:0] rx_shreg;
  logic            rx_par;
  logic            wr_stb;
  logic [DATA-1:0] wr_byte;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shreg   <= '0;
      rx_par     <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      wr_stb     <= 1'b0;
      wr_byte    <= '0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      wr_stb     <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_BREAK: if (rx_s2) rx_state <= RX_IDLE;
        default: begin
          if (rx_cnt != CNT_LAST) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt <= '0;
            case (rx_state)
              RX_DATA: begin
                rx_shreg <= {rx_s2, rx_shreg[DATA-1:1]};
                if (rx_bit == DATA_LAST) rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                else rx_bit <= rx_bit + 1'b1;
              end
              RX_PARITY: begin
                rx_par   <= rx_s2;
                rx_state <= RX_STOP;
              end
              RX_STOP: begin
                // Only the first stop bit is sampled; the FSM is ready for a new start immediately.
                if (!rx_s2) begin
                  frame_err <= 1'b1;
                  rx_state  <= RX_BREAK;
                end else begin
                  rx_state <= RX_IDLE;
                  if (PARITY != 0 && parity_bit(9'(rx_shreg), PMODE) != rx_par) begin
                    parity_err <= 1'b1;
                  end else begin
                    wr_stb  <= 1'b1;
                    wr_byte <= rx_shreg;
                  end
                end
              end
              default: rx_state <= RX_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // ---------------- receive output stage ----------------
`ifdef UART_RX_FIFO_EN
  logic fifo_empty;
  logic fifo_full;

  uart_rx_fifo #(
    .W     (DATA),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_stb),
    .wr_data (wr_byte),
    .rd_en   (rx_ready),
    .rd_data (rx_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign rx_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst) overrun <= 1'b0;
    else      overrun <= wr_stb && fifo_full && !rx_ready;
  end
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (wr_stb) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_data  <= wr_byte;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_frame.sv
// Self-checking bench for uart_frame: 8N1 TX, 8E2 loopback, 7O1 RX, error and reset corners.
module tb_uart_frame;

  localparam int CLOCK = 160;
  localparam int BAUD  = 10;
  localparam int DIV   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // A: 8N1, rx driven by bench
  logic [7:0] tx_data_a = '0, rx_data_a;
  logic tx_valid_a = 1'b0, tx_ready_a, tx_a, rx_a = 1'b1, rx_valid_a, rx_ready_a = 1'b1;
  logic ferr_a, perr_a, ovr_a;
  // B: 8E2, tx looped back to rx
  logic [7:0] tx_data_b = '0, rx_data_b;
  logic tx_valid_b = 1'b0, tx_ready_b, tx_b, rx_valid_b, rx_ready_b = 1'b1;
  logic ferr_b, perr_b, ovr_b;
  // C: 7O1, rx driven by bench
  logic [6:0] tx_data_c = '0, rx_data_c;
  logic tx_valid_c = 1'b0, tx_ready_c, tx_c, rx_c = 1'b1, rx_valid_c, rx_ready_c = 1'b1;
  logic ferr_c, perr_c, ovr_c;

  uart_frame #(.CLOCK(CLOCK), .BAUD(BAUD), .DATA(8), .PARITY(0), .STOP(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .tx(tx_a), .rx(rx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a));

  uart_frame #(.CLOCK(CLOCK), .BAUD(BAUD), .DATA(8), .PARITY(1), .STOP(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .tx(tx_b), .rx(tx_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b));

  uart_frame #(.CLOCK(CLOCK), .BAUD(BAUD), .DATA(7), .PARITY(2), .STOP(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c),
    .tx(tx_c), .rx(rx_c), .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_ready(rx_ready_c),
    .frame_err(ferr_c), .parity_err(perr_c), .overrun(ovr_c));

  int n_vec = 0;
  int n_err = 0;

  // Event monitors: pulse counts and accepted bytes per instance (0=A, 1=B, 2=C).
  int ferr_n[3] = '{0, 0, 0};
  int perr_n[3] = '{0, 0, 0};
  int ovr_n[3]  = '{0, 0, 0};
  logic [7:0] rxq_a[$], rxq_b[$], rxq_c[$];

  always @(negedge clk) begin
    if (ferr_a) ferr_n[0]++;
    if (perr_a) perr_n[0]++;
    if (ovr_a)  ovr_n[0]++;
    if (ferr_b) ferr_n[1]++;
    if (perr_b) perr_n[1]++;
    if (ovr_b)  ovr_n[1]++;
    if (ferr_c) ferr_n[2]++;
    if (perr_c) perr_n[2]++;
    if (ovr_c)  ovr_n[2]++;
    if (rx_valid_a && rx_ready_a) rxq_a.push_back(rx_data_a);
    if (rx_valid_b && rx_ready_b) rxq_b.push_back(rx_data_b);
    if (rx_valid_c && rx_ready_c) rxq_c.push_back({1'b0, rx_data_c});
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference frame: bit k in time order at index k (start, data LSB first, parity, stops).
  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int nd, input int pm,
                                             input bit flip, input bit stopv, input int ns);
    logic [15:0] f;
    int ones;
    int pos;
    logic p;
    f    = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < nd; i++) begin
      f[1+i] = d[i];
      if (d[i]) ones++;
    end
    pos = 1 + nd;
    if (pm != 0) begin
      p = (ones % 2) == 1;
      if (pm == 2) p = !p;
      f[pos] = p ^ flip;
      pos++;
    end
    f[pos] = stopv;
    for (int s = 1; s < ns; s++) f[pos+s] = 1'b1;
    return f;
  endfunction

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else rx_c = v;
  endtask

  task automatic drive_rx(input int sel, input logic [15:0] f, input int n,
                          input logic tail, input int tail_cyc);
    for (int b = 0; b < n; b++) begin
      set_rx(sel, f[b]);
      tick(DIV);
    end
    set_rx(sel, tail);
    tick(tail_cyc);
  endtask

  // Sends one byte on A (sel 0) or B (sel 1), checking every cycle of the waveform and tx_ready.
  task automatic run_tx(input int sel, input logic [7:0] d, input logic [15:0] seq,
                        input int nb, input string nm);
    logic [15:0] got;
    logic rdy_busy;
    logic cur_tx;
    logic cur_rdy;
    got      = seq;
    rdy_busy = 1'b0;
    if (sel == 0) begin
      tx_data_a = d; tx_valid_a = 1'b1;
    end else begin
      tx_data_b = d; tx_valid_b = 1'b1;
    end
    tick();
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
    for (int k = 0; k < nb * DIV; k++) begin
      cur_tx  = (sel == 0) ? tx_a : tx_b;
      cur_rdy = (sel == 0) ? tx_ready_a : tx_ready_b;
      if (cur_tx !== seq[k/DIV]) got[k/DIV] = cur_tx;
      rdy_busy = rdy_busy | cur_rdy;
      tick();
    end
    for (int b = 0; b < nb; b++)
      check($sformatf("%s 0x%02h bit%0d", nm, d, b), 32'(got[b]), 32'(seq[b]));
    check($sformatf("%s 0x%02h tx_ready busy", nm, d), 32'(rdy_busy), 32'd0);
    cur_rdy = (sel == 0) ? tx_ready_a : tx_ready_b;
    check($sformatf("%s 0x%02h tx_ready return", nm, d), 32'(cur_rdy), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  d;
    logic [15:0] seq;
  } txvec_t;

  typedef struct {
    logic [6:0] d;
    bit flip;
    bit stopv;
    bit exp_valid;
    bit exp_perr;
    bit exp_ferr;
  } rxvec_t;

  txvec_t tx_tbl[4];
  rxvec_t rx_tbl[6];

  initial begin
    int q0, f0, p0, o0;
    logic [7:0] d;
    logic [15:0] f;

    tx_tbl[0] = '{8'hA5, 16'b111111_1_10100101_0};
    tx_tbl[1] = '{8'h00, 16'b111111_1_00000000_0};
    tx_tbl[2] = '{8'hFF, 16'b111111_1_11111111_0};
    tx_tbl[3] = '{8'h3C, 16'b111111_1_00111100_0};

    rx_tbl[0] = '{7'h55, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    rx_tbl[1] = '{7'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    rx_tbl[2] = '{7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    rx_tbl[3] = '{7'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    rx_tbl[4] = '{7'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rx_tbl[5] = '{7'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset values
    tick(3);
    check("reset tx", 32'(tx_a), 32'd1);
    check("reset tx_ready", 32'(tx_ready_a), 32'd1);
    check("reset rx_valid", 32'(rx_valid_a), 32'd0);
    check("reset rx_data", 32'(rx_data_a), 32'd0);
    check("reset frame_err", 32'(ferr_a), 32'd0);
    check("reset parity_err", 32'(perr_c), 32'd0);
    check("reset overrun", 32'(ovr_a), 32'd0);
    rst = 1'b1;
    tick(2);

    // 8N1 transmit waveform table
    foreach (tx_tbl[i]) run_tx(0, tx_tbl[i].d, tx_tbl[i].seq, 10, "8N1");

    // 8E2 loopback: 0x3C then random bytes
    for (int i = 0; i < 7; i++) begin
      d  = (i == 0) ? 8'h3C : 8'($urandom_range(0, 255));
      q0 = rxq_b.size();
      f0 = ferr_n[1]; p0 = perr_n[1]; o0 = ovr_n[1];
      run_tx(1, d, frame_bits({1'b0, d}, 8, 1, 1'b0, 1'b1, 2), 12, "8E2");
      tick(2);
      check($sformatf("8E2 0x%02h rx count", d), 32'(rxq_b.size() - q0), 32'd1);
      if (rxq_b.size() > q0) check($sformatf("8E2 0x%02h rx_data", d), 32'(rxq_b[q0]), 32'(d));
      check($sformatf("8E2 0x%02h error pulses", d),
            32'((ferr_n[1] - f0) + (perr_n[1] - p0) + (ovr_n[1] - o0)), 32'd0);
    end

    // 7O1 receive table
    foreach (rx_tbl[i]) begin
      q0 = rxq_c.size();
      f0 = ferr_n[2]; p0 = perr_n[2];
      f  = frame_bits({2'b0, rx_tbl[i].d}, 7, 2, rx_tbl[i].flip, rx_tbl[i].stopv, 1);
      drive_rx(1, f, 10, 1'b1, 2 * DIV);
      check($sformatf("7O1[%0d] rx count", i), 32'(rxq_c.size() - q0), 32'(rx_tbl[i].exp_valid));
      check($sformatf("7O1[%0d] parity_err", i), 32'(perr_n[2] - p0), 32'(rx_tbl[i].exp_perr));
      check($sformatf("7O1[%0d] frame_err", i), 32'(ferr_n[2] - f0), 32'(rx_tbl[i].exp_ferr));
      if (rx_tbl[i].exp_valid && rxq_c.size() > q0)
        check($sformatf("7O1[%0d] rx_data", i), 32'(rxq_c[q0]), 32'(rx_tbl[i].d));
    end

    // Stop bit 0 followed by a held-low line, then a clean frame
    q0 = rxq_a.size();
    f0 = ferr_n[0];
    drive_rx(0, frame_bits(9'h081, 8, 0, 1'b0, 1'b0, 1), 10, 1'b0, 100);
    rx_a = 1'b1;
    tick(2 * DIV);
    check("break frame_err count", 32'(ferr_n[0] - f0), 32'd1);
    check("break rx count", 32'(rxq_a.size() - q0), 32'd0);
    drive_rx(0, frame_bits(9'h042, 8, 0, 1'b0, 1'b1, 1), 10, 1'b1, 2 * DIV);
    check("after break rx count", 32'(rxq_a.size() - q0), 32'd1);
    if (rxq_a.size() > q0) check("after break rx_data", 32'(rxq_a[q0]), 32'h42);

    // Short glitch on an idle line
    q0 = rxq_a.size();
    f0 = ferr_n[0]; p0 = perr_n[0]; o0 = ovr_n[0];
    rx_a = 1'b0;
    tick(4);
    rx_a = 1'b1;
    tick(3 * DIV);
    check("glitch rx count", 32'(rxq_a.size() - q0), 32'd0);
    check("glitch flags", 32'((ferr_n[0] - f0) + (perr_n[0] - p0) + (ovr_n[0] - o0)), 32'd0);
    check("glitch rx_valid", 32'(rx_valid_a), 32'd0);

    // Overrun with consumer stalled
    rx_ready_a = 1'b0;
    q0 = rxq_a.size();
    o0 = ovr_n[0];
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 5; i++)
      drive_rx(0, frame_bits(9'(8'h11 * i), 8, 0, 1'b0, 1'b1, 1), 10, 1'b1, 2 * DIV);
    check("fifo overrun count", 32'(ovr_n[0] - o0), 32'd1);
    check("fifo rx_valid", 32'(rx_valid_a), 32'd1);
    check("fifo head", 32'(rx_data_a), 32'h11);
    rx_ready_a = 1'b1;
    tick(8);
    check("fifo drained count", 32'(rxq_a.size() - q0), 32'd4);
    for (int i = 0; i < 4 && q0 + i < rxq_a.size(); i++)
      check($sformatf("fifo entry %0d", i), 32'(rxq_a[q0+i]), 32'(8'h11 * (i + 1)));
`else
    drive_rx(0, frame_bits(9'h011, 8, 0, 1'b0, 1'b1, 1), 10, 1'b1, 2 * DIV);
    drive_rx(0, frame_bits(9'h022, 8, 0, 1'b0, 1'b1, 1), 10, 1'b1, 2 * DIV);
    check("overrun count", 32'(ovr_n[0] - o0), 32'd1);
    check("overrun rx_valid", 32'(rx_valid_a), 32'd1);
    check("overrun kept byte", 32'(rx_data_a), 32'h11);
    rx_ready_a = 1'b1;
    tick(2);
    check("overrun drained count", 32'(rxq_a.size() - q0), 32'd1);
    if (rxq_a.size() > q0) check("overrun drained byte", 32'(rxq_a[q0]), 32'h11);
    check("overrun rx_valid cleared", 32'(rx_valid_a), 32'd0);
`endif

    // Reset in the middle of a TX data bit (0xF0 bit 2 drives tx low)
    tx_data_a = 8'hF0; tx_valid_a = 1'b1;
    tick();
    tx_valid_a = 1'b0;
    tick(3 * DIV + 5);
    check("mid-tx tx level", 32'(tx_a), 32'd0);
    rst = 1'b0;
    tick();
    check("tx reset tx", 32'(tx_a), 32'd1);
    check("tx reset tx_ready", 32'(tx_ready_a), 32'd1);
    rst = 1'b1;
    tick(2);

    // Reset in the middle of an RX frame with a byte still pending
    rx_ready_a = 1'b0;
    drive_rx(0, frame_bits(9'h077, 8, 0, 1'b0, 1'b1, 1), 10, 1'b1, 2 * DIV);
    check("pending rx_valid", 32'(rx_valid_a), 32'd1);
    f = frame_bits(9'h05A, 8, 0, 1'b0, 1'b1, 1);
    for (int b = 0; b < 5; b++) begin
      rx_a = f[b];
      tick(DIV);
    end
    rst = 1'b0;
    tick();
    check("rx reset rx_valid", 32'(rx_valid_a), 32'd0);
    check("rx reset rx_data", 32'(rx_data_a), 32'd0);
    rst = 1'b1;
    rx_a = 1'b1;
    rx_ready_a = 1'b1;
    q0 = rxq_a.size();
    f0 = ferr_n[0];
    tick(3 * DIV);
    drive_rx(0, frame_bits(9'h099, 8, 0, 1'b0, 1'b1, 1), 10, 1'b1, 2 * DIV);
    check("post-reset rx count", 32'(rxq_a.size() - q0), 32'd1);
    if (rxq_a.size() > q0) check("post-reset rx_data", 32'(rxq_a[q0]), 32'h99);
    check("post-reset frame_err", 32'(ferr_n[0] - f0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
